// File: rtl/cache_fill_ctrl_if.sv
// Purpose : bundles the miss-fill controller's request, memory and cache-write signals.
// Latency : none, wiring only.
// Backpressure: none; the memory side accepts one read per cycle and returns in issue order.
// Ports   : master = fill controller (drives stall/busy/mem/cache/fill signals),
//           slave  = caches + memory (drive miss_req/miss_addr/mem_rdata/mem_rvalid).
interface cache_fill_ctrl_if #(
   parameter int AWIDTH = 16,
   parameter int DWIDTH = 16,
   parameter int WPB    = 8,
   parameter int NCH    = 2
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int WW  = $clog2(WPB);

   logic [NCH-1:0]        miss_req;
   logic [NCH*AWIDTH-1:0] miss_addr;
   logic                  stall;
   logic                  busy;
   logic [CHW-1:0]        active_ch;
   logic                  mem_en;
   logic [AWIDTH-1:0]     mem_addr;
   logic [DWIDTH-1:0]     mem_rdata;
   logic                  mem_rvalid;
   logic                  cache_wr_en;
   logic [WW-1:0]         cache_wr_word;
   logic [DWIDTH-1:0]     cache_wr_data;
   logic                  cache_tag_wr;
   logic [AWIDTH-1:0]     fill_addr;
   logic [NCH-1:0]        fill_done;

   modport master (
      input  miss_req, miss_addr, mem_rdata, mem_rvalid,
      output stall, busy, active_ch, mem_en, mem_addr,
             cache_wr_en, cache_wr_word, cache_wr_data, cache_tag_wr,
             fill_addr, fill_done
   );

   modport slave (
      output miss_req, miss_addr, mem_rdata, mem_rvalid,
      input  stall, busy, active_ch, mem_en, mem_addr,
             cache_wr_en, cache_wr_word, cache_wr_data, cache_tag_wr,
             fill_addr, fill_done
   );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Purpose : arbitrates block misses from NCH caches (lowest index wins) and streams one block
//           from pipelined main memory into the granted cache, then writes its tag.
// Latency : grant at edge t, word k issued in cycle t+1+k, done pulse in cycle t+WPB+L+1.
// Backpressure: none toward memory (one read per cycle, no gaps); the pipeline is held via stall.
// Ports   : clk, rst (sync, active-high); bus = cache_fill_ctrl_if.master carrying
//           miss_req/miss_addr in, mem_en/mem_addr out, mem_rdata/mem_rvalid in,
//           cache_wr_*/cache_tag_wr/fill_addr/fill_done out, plus stall/busy/active_ch.
module cache_fill_ctrl #(
   parameter int AWIDTH = 16,
   parameter int DWIDTH = 16,
   parameter int WPB    = 8,
   parameter int NCH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   cache_fill_ctrl_if.master bus
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int WW  = $clog2(WPB);
   localparam int CW  = WW + 1;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     issue_cnt;
   logic [CW-1:0]     recv_cnt;
   logic [CHW-1:0]    active_ch_q;
   logic [AWIDTH-1:0] fill_addr_q;
   logic [AWIDTH-1:0] mem_addr_q;
   logic              mem_en_q;
   logic              tag_wr_q;
   logic [NCH-1:0]    fill_done_q;

   logic              grant_vld;
   logic [CHW-1:0]    grant_ch;
   logic [AWIDTH-1:0] grant_addr;
   logic [AWIDTH-1:0] grant_base;
   logic              rx;

   // Scan from the top so the lowest-index requester is the last (winning) assignment.
   always_comb begin
      grant_vld  = 1'b0;
      grant_ch   = '0;
      grant_addr = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (bus.miss_req[i]) begin
            grant_vld  = 1'b1;
            grant_ch   = CHW'(i);
            grant_addr = bus.miss_addr[i*AWIDTH +: AWIDTH];
         end
      end
   end

   // Block base: clear the byte-in-word bit and the word-in-block bits.
   assign grant_base = grant_addr & ~AWIDTH'(2*WPB - 1);

   // Returns outside FILL (idle, done, or stale after a reset) are dropped.
   assign rx = (state == FILL) && bus.mem_rvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         issue_cnt   <= '0;
         recv_cnt    <= '0;
         active_ch_q <= '0;
         fill_addr_q <= '0;
         mem_addr_q  <= '0;
         mem_en_q    <= 1'b0;
         tag_wr_q    <= 1'b0;
         fill_done_q <= '0;
      end else begin
         tag_wr_q    <= 1'b0;
         fill_done_q <= '0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  state       <= FILL;
                  active_ch_q <= grant_ch;
                  fill_addr_q <= grant_base;
                  mem_addr_q  <= grant_base;
                  mem_en_q    <= 1'b1;
                  issue_cnt   <= '0;
                  recv_cnt    <= '0;
               end
            end
            FILL: begin
               // Issue side: mem_en/mem_addr are registered, so the next address is
               // prepared one cycle ahead and mem_en drops after the last word.
               if (mem_en_q) begin
                  issue_cnt  <= issue_cnt + CW'(1);
                  mem_addr_q <= mem_addr_q + AWIDTH'(2);
                  if (issue_cnt == CW'(WPB - 1)) begin
                     mem_en_q <= 1'b0;
                  end
               end
               // Return side advances independently of the issue side.
               if (bus.mem_rvalid) begin
                  recv_cnt <= recv_cnt + CW'(1);
                  if (recv_cnt == CW'(WPB - 1)) begin
                     state       <= DONE;
                     mem_en_q    <= 1'b0;
                     tag_wr_q    <= 1'b1;
                     fill_done_q <= NCH'(1) << active_ch_q;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy          = (state != IDLE);
   assign bus.stall         = (|bus.miss_req) | (state != IDLE);
   assign bus.active_ch     = active_ch_q;
   assign bus.mem_en        = mem_en_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.cache_wr_en   = rx;
   assign bus.cache_wr_word = recv_cnt[WW-1:0];
   assign bus.cache_wr_data = bus.mem_rdata;
   assign bus.cache_tag_wr  = tag_wr_q;
   assign bus.fill_addr     = fill_addr_q;
   assign bus.fill_done     = fill_done_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Purpose : directed bench for cache_fill_ctrl, default config plus a WPB=4/NCH=4 instance.
// Latency : memory model returns L0=4 / L1=2 cycles after issue, optional one-cycle bubble.
// Backpressure: none; the memory model accepts every issued read.
module tb_cache_fill_ctrl;
   localparam int L0 = 4;
   localparam int L1 = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_fill_ctrl_if #(.AWIDTH(16), .DWIDTH(16), .WPB(8), .NCH(2)) bus0 ();
   cache_fill_ctrl_if #(.AWIDTH(16), .DWIDTH(16), .WPB(4), .NCH(4)) bus1 ();

   cache_fill_ctrl #(.AWIDTH(16), .DWIDTH(16), .WPB(8), .NCH(2)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   cache_fill_ctrl #(.AWIDTH(16), .DWIDTH(16), .WPB(4), .NCH(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // Memory model: in-order pipeline, return due L cycles after issue.
   logic [15:0] q0_addr[$];
   int          q0_due[$];
   logic [15:0] q1_addr[$];
   int          q1_due[$];
   int          rets0   = 0;
   bit          bubble0 = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (bus0.mem_en === 1'b1) begin
         q0_addr.push_back(bus0.mem_addr);
         q0_due.push_back(cyc + L0 - 1);
      end
      if (bus1.mem_en === 1'b1) begin
         q1_addr.push_back(bus1.mem_addr);
         q1_due.push_back(cyc + L1 - 1);
      end
      #1;
      bus0.mem_rvalid = 1'b0;
      bus1.mem_rvalid = 1'b0;
      if (q0_due.size() > 0 && q0_due[0] <= cyc) begin
         if (bubble0 && rets0 == 3) begin
            bubble0 = 1'b0;
         end else begin
            bus0.mem_rvalid = 1'b1;
            bus0.mem_rdata  = mdata(q0_addr.pop_front());
            void'(q0_due.pop_front());
            rets0++;
         end
      end
      if (q1_due.size() > 0 && q1_due[0] <= cyc) begin
         bus1.mem_rvalid = 1'b1;
         bus1.mem_rdata  = mdata(q1_addr.pop_front());
         void'(q1_due.pop_front());
      end
   end

   // Monitor: logs issues, writes and completions, sampled on the falling edge.
   logic [15:0] iss0[$];
   int          wr0_word[$];
   logic [15:0] wr0_dat[$];
   int          wr0_cyc[$];
   logic [1:0]  dn0[$];
   int          dn0_cyc[$];
   int          tag0       = 0;
   int          rv0        = 0;
   int          stall_low0 = 0;
   bit          watch0     = 1'b0;
   logic [15:0] iss1[$];
   logic [3:0]  dn1[$];
   int          wr1        = 0;

   always @(negedge clk) begin
      if (bus0.mem_en === 1'b1) iss0.push_back(bus0.mem_addr);
      if (bus0.cache_wr_en === 1'b1) begin
         wr0_word.push_back(int'(bus0.cache_wr_word));
         wr0_dat.push_back(bus0.cache_wr_data);
         wr0_cyc.push_back(cyc + 1);
      end
      if (bus0.fill_done !== 2'b00) begin
         dn0.push_back(bus0.fill_done);
         dn0_cyc.push_back(cyc + 1);
      end
      if (bus0.cache_tag_wr === 1'b1) tag0++;
      if (bus0.mem_rvalid === 1'b1) rv0++;
      if (watch0 && bus0.stall !== 1'b1) stall_low0++;
      if (bus1.mem_en === 1'b1) iss1.push_back(bus1.mem_addr);
      if (bus1.cache_wr_en === 1'b1) wr1++;
      if (bus1.fill_done !== 4'b0000) dn1.push_back(bus1.fill_done);
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear0();
      iss0.delete(); wr0_word.delete(); wr0_dat.delete(); wr0_cyc.delete();
      dn0.delete(); dn0_cyc.delete();
      tag0 = 0; stall_low0 = 0;
   endtask

   task automatic wait_done0(input int n, input string tag);
      int k = 0;
      while (dn0.size() < n && k < 100) begin
         step();
         k++;
      end
      chk(tag, 32'(dn0.size() >= n), 32'd1);
   endtask

   task automatic wait_done1(input int n, input string tag);
      int k = 0;
      while (dn1.size() < n && k < 100) begin
         step();
         k++;
      end
      chk(tag, 32'(dn1.size() >= n), 32'd1);
   endtask

   initial begin
      int t;
      int n;
      int rv_start;
      int k;
      bus0.miss_req = '0; bus0.miss_addr = '0; bus0.mem_rvalid = 1'b0; bus0.mem_rdata = '0;
      bus1.miss_req = '0; bus1.miss_addr = '0; bus1.mem_rvalid = 1'b0; bus1.mem_rdata = '0;

      // Reset state
      rst = 1'b1;
      step(3);
      chk("rst_busy",      32'(bus0.busy),         0);
      chk("rst_stall",     32'(bus0.stall),        0);
      chk("rst_mem_en",    32'(bus0.mem_en),       0);
      chk("rst_wr_en",     32'(bus0.cache_wr_en),  0);
      chk("rst_tag",       32'(bus0.cache_tag_wr), 0);
      chk("rst_done",      32'(bus0.fill_done),    0);
      chk("rst_active",    32'(bus0.active_ch),    0);
      chk("rst_fill_addr", 32'(bus0.fill_addr),    0);
      chk("rst_busy1",     32'(bus1.busy),         0);
      rst = 1'b0;
      step();

      // Single D-miss at 0x1236
      clear0();
      bus0.miss_addr = {16'h0000, 16'h1236};
      bus0.miss_req  = 2'b01;
      t = cyc + 1;
      watch0 = 1'b1;
      wait_done0(1, "t1_timeout");
      watch0 = 1'b0;
      chk("t1_fill_addr", 32'(bus0.fill_addr), 32'h1230);
      bus0.miss_req = 2'b00;
      step();
      chk("t1_stall_drop", 32'(bus0.stall), 0);
      chk("t1_iss_n", 32'(iss0.size()), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("t1_iss%0d", i), 32'(iss0[i]), 32'h1230 + 32'(2*i));
      chk("t1_wr_n", 32'(wr0_word.size()), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_wword%0d", i), 32'(wr0_word[i]), 32'(i));
         chk($sformatf("t1_wdata%0d", i), 32'(wr0_dat[i]), 32'(mdata(16'(16'h1230 + 2*i))));
      end
      chk("t1_done_val", 32'(dn0[0]), 32'b01);
      chk("t1_done_cyc", 32'(dn0_cyc[0]), 32'(t + 13));
      chk("t1_tag", 32'(tag0), 1);
      chk("t1_stall_hi", 32'(stall_low0), 0);

      // Simultaneous D- and I-miss
      clear0();
      bus0.miss_addr = {16'h0040, 16'h8000};
      bus0.miss_req  = 2'b11;
      t = cyc + 1;
      watch0 = 1'b1;
      wait_done0(1, "t2_timeout_a");
      chk("t2_done_a", 32'(dn0[0]), 32'b01);
      bus0.miss_req = 2'b10;
      step(3);
      chk("t2_active_b", 32'(bus0.active_ch), 1);
      chk("t2_busy_b", 32'(bus0.busy), 1);
      wait_done0(2, "t2_timeout_b");
      watch0 = 1'b0;
      bus0.miss_req = 2'b00;
      step();
      chk("t2_stall_drop", 32'(bus0.stall), 0);
      chk("t2_done_b", 32'(dn0[1]), 32'b10);
      chk("t2_cyc_a", 32'(dn0_cyc[0]), 32'(t + 13));
      chk("t2_cyc_b", 32'(dn0_cyc[1]), 32'(t + 27));
      chk("t2_iss_n", 32'(iss0.size()), 16);
      for (int i = 0; i < 16; i++) begin
         k = (i < 8) ? (32'h8000 + 2*i) : (32'h0040 + 2*(i-8));
         chk($sformatf("t2_iss%0d", i), 32'(iss0[i]), 32'(k));
         chk($sformatf("t2_wword%0d", i), 32'(wr0_word[i]), 32'(i % 8));
         chk($sformatf("t2_wdata%0d", i), 32'(wr0_dat[i]), 32'(mdata(16'(k))));
      end
      chk("t2_stall_hi", 32'(stall_low0), 0);
      chk("t2_tag", 32'(tag0), 2);

      // Reset mid-fill after three writes
      clear0();
      bus0.miss_addr = {16'h0000, 16'h2000};
      bus0.miss_req  = 2'b01;
      k = 0;
      while (wr0_word.size() < 3 && k < 50) begin
         step();
         k++;
      end
      chk("t3_reach3", 32'(wr0_word.size() >= 3), 1);
      rst = 1'b1;
      bus0.miss_req = 2'b00;
      step();
      chk("t3_mem_en",    32'(bus0.mem_en),       0);
      chk("t3_busy",      32'(bus0.busy),         0);
      chk("t3_stall",     32'(bus0.stall),        0);
      chk("t3_wr_en",     32'(bus0.cache_wr_en),  0);
      chk("t3_tag",       32'(bus0.cache_tag_wr), 0);
      chk("t3_done",      32'(bus0.fill_done),    0);
      chk("t3_fill_addr", 32'(bus0.fill_addr),    0);
      rst = 1'b0;
      n = wr0_word.size();
      rv_start = rv0;
      step(8);
      chk("t3_stale_rv", 32'(rv0 > rv_start), 1);
      chk("t3_no_wr", 32'(wr0_word.size()), 32'(n));
      chk("t3_no_done", 32'(dn0.size()), 0);
      chk("t3_no_tag", 32'(tag0), 0);
      clear0();
      bus0.miss_req = 2'b01;
      wait_done0(1, "t3_timeout");
      bus0.miss_req = 2'b00;
      step();
      chk("t3_wr_n", 32'(wr0_word.size()), 8);
      chk("t3_word0", 32'(wr0_word[0]), 0);
      chk("t3_iss0", 32'(iss0[0]), 32'h2000);
      chk("t3_wdata7", 32'(wr0_dat[7]), 32'(mdata(16'h200E)));

      // Memory bubble after the third return
      clear0();
      rets0   = 0;
      bubble0 = 1'b1;
      bus0.miss_addr = {16'h0000, 16'h3000};
      bus0.miss_req  = 2'b01;
      t = cyc + 1;
      wait_done0(1, "t4_timeout");
      bus0.miss_req = 2'b00;
      step();
      chk("t4_wr_n", 32'(wr0_word.size()), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t4_wword%0d", i), 32'(wr0_word[i]), 32'(i));
         chk($sformatf("t4_wdata%0d", i), 32'(wr0_dat[i]), 32'(mdata(16'(16'h3000 + 2*i))));
      end
      chk("t4_gap", 32'(wr0_cyc[3]), 32'(wr0_cyc[2] + 2));
      chk("t4_done_cyc", 32'(dn0_cyc[0]), 32'(t + 14));
      chk("t4_done_after_last", 32'(dn0_cyc[0]), 32'(wr0_cyc[7] + 1));

      // WPB=4, NCH=4: ch2 and ch3 at 0xFFFA, ch2 drops its request mid-fill
      iss1.delete(); dn1.delete(); wr1 = 0;
      bus1.miss_addr = {16'hFFFA, 16'hFFFA, 16'h0000, 16'h0000};
      bus1.miss_req  = 4'b1100;
      step(2);
      chk("t5_active", 32'(bus1.active_ch), 2);
      chk("t5_base", 32'(bus1.fill_addr), 32'hFFF8);
      bus1.miss_req = 4'b1000;
      wait_done1(1, "t5_timeout_a");
      chk("t5_done_a", 32'(dn1[0]), 32'b0100);
      wait_done1(2, "t5_timeout_b");
      chk("t5_done_b", 32'(dn1[1]), 32'b1000);
      bus1.miss_req = 4'b0000;
      step();
      chk("t5_iss_n", 32'(iss1.size()), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("t5_iss%0d", i), 32'(iss1[i]), 32'hFFF8 + 32'(2*(i % 4)));
      chk("t5_wr_n", 32'(wr1), 8);
      chk("t5_stall_drop", 32'(bus1.stall), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
